// File: rtl/alu4_pkg.sv
// Shared types and constants for the 4-bit registered ALU.
package alu4_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu4_comb.sv
// Combinational ALU datapath: next result and carry/borrow flag from operands and op.
module alu4_comb
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result_c,
    output logic             overflow_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit captures the carry-out (ADD) or the borrow (SUB wraps negative).
    assign sum  = {1'b0, input1} + {1'b0, input2};
    assign diff = {1'b0, input1} - {1'b0, input2};

    always_comb begin
        result_c   = '0;
        overflow_c = 1'b0;
        case (op)
            ADD: begin
                result_c   = sum[WIDTH-1:0];
                overflow_c = sum[WIDTH];
            end
            SUB: begin
                result_c   = diff[WIDTH-1:0];
                overflow_c = diff[WIDTH];
            end
            AND: result_c = input1 & input2;
            OR:  result_c = input1 | input2;
            default: begin
                result_c   = '0;
                overflow_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu4.sv
// 4-bit ALU with one-cycle latency: registered result, carry/borrow, zero and valid.
module alu4
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  alu_op_t          op,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] result_c;
    logic             overflow_c;

    alu4_comb #(.WIDTH(WIDTH)) u_comb (
        .input1     (input1),
        .input2     (input2),
        .op         (op),
        .result_c   (result_c),
        .overflow_c (overflow_c)
    );

    // Data registers load only on valid so idle-cycle inputs never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= result_c;
                overflow <= overflow_c;
                zero     <= (result_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu4.sv
// Directed and exhaustive checks for alu4: latency, flags, hold on idle, async reset.
module tb_alu4;
    import alu4_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] input1;
    logic [3:0] input2;
    alu_op_t    op;
    logic       in_valid;
    logic [3:0] result;
    logic       overflow;
    logic       zero;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    alu4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input1    (input1),
        .input2    (input2),
        .op        (op),
        .in_valid  (in_valid),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {overflow, result}, written with plain integer arithmetic.
    function automatic logic [4:0] model(input int k, input int a, input int b);
        int r;
        int v;
        r = 0;
        v = 0;
        case (k)
            0: begin r = (a + b) % 16; v = (a + b > 15) ? 1 : 0; end
            1: begin r = (a - b + 16) % 16; v = (a < b) ? 1 : 0; end
            2: r = a & b;
            default: r = a | b;
        endcase
        return {1'(v), 4'(r)};
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0;
        input1   = 'x;
        input2   = 'x;
    endtask

    // One operation, then one idle cycle checking out_valid drops and data holds.
    task automatic run_one(input string tag, input alu_op_t o, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] er, input logic eo,
                           input logic ez);
        @(negedge clk);
        op = o; input1 = a; input2 = b; in_valid = 1'b1;
        @(negedge clk);
        drive_idle();
        check({tag, ".result"},    32'(result),    32'(er));
        check({tag, ".overflow"},  32'(overflow),  32'(eo));
        check({tag, ".zero"},      32'(zero),      32'(ez));
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        @(negedge clk);
        check({tag, ".gap_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".gap_hold"},  32'({zero, overflow, result}), 32'({ez, eo, er}));
    endtask

    initial begin
        logic [6:0] exp_q;
        logic       have_prev;

        rst_n = 1'b1;
        op    = ADD;
        drive_idle();
        #1 rst_n = 1'b0;
        #1;
        check("reset.result",    32'(result),    32'd0);
        check("reset.overflow",  32'(overflow),  32'd0);
        check("reset.zero",      32'(zero),      32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset.out_valid", 32'(out_valid), 32'd0);

        run_one("add_4_3",   ADD, 4'b0100, 4'b0011, 4'b0111, 1'b0, 1'b0);
        run_one("sub_10_4",  SUB, 4'b1010, 4'b0100, 4'b0110, 1'b0, 1'b0);
        run_one("sub_3_5",   SUB, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0);
        run_one("and",       AND, 4'b1010, 4'b1100, 4'b1000, 1'b0, 1'b0);
        run_one("or",        OR,  4'b1010, 4'b1100, 4'b1110, 1'b0, 1'b0);
        run_one("add_wrap",  ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
        run_one("sub_equal", SUB, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1);
        run_one("and_zero",  AND, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b1);
        run_one("or_ones",   OR,  4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b0);

        // Back-to-back sweep of every operand pair for every op.
        have_prev = 1'b0;
        exp_q     = '0;
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    @(negedge clk);
                    if (have_prev)
                        check("sweep", 32'({out_valid, zero, overflow, result}), 32'(exp_q));
                    op = alu_op_t'(k); input1 = 4'(a); input2 = 4'(b); in_valid = 1'b1;
                    exp_q = {1'b1, (model(k, a, b) & 5'h0f) == 5'h00, model(k, a, b)};
                    have_prev = 1'b1;
                end
            end
        end
        @(negedge clk);
        drive_idle();
        check("sweep.last", 32'({out_valid, zero, overflow, result}), 32'(exp_q));
        @(negedge clk);
        check("sweep.gap", 32'({out_valid, zero, overflow, result}), 32'({1'b0, exp_q[5:0]}));

        // Reset between edges while an operation is in flight.
        @(negedge clk);
        op = ADD; input1 = 4'b0100; input2 = 4'b0011; in_valid = 1'b1;
        @(negedge clk);
        check("pre_reset.result", 32'(result), 32'd7);
        op = ADD; input1 = 4'b0001; input2 = 4'b0001; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset.result",    32'(result),    32'd0);
        check("async_reset.zero",      32'(zero),      32'd1);
        check("async_reset.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        drive_idle();
        check("in_reset.out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset.out_valid", 32'(out_valid), 32'd0);
        check("post_reset.result",    32'(result),    32'd0);

        run_one("first_after_reset", ADD, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
